// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access path: size codes, FSM states, latched request.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_pkg;

    // Size codes shared with the control unit's MemRead/MemWrite outputs
    localparam logic [1:0] SZ_NONE = 2'b00;
    localparam logic [1:0] SZ_B    = 2'b01;
    localparam logic [1:0] SZ_H    = 2'b10;
    localparam logic [1:0] SZ_W    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Attributes of the access in flight, latched when the request is accepted
    typedef struct packed {
        logic       we;
        logic [1:0] size;
        logic [1:0] lane;
    } acc_t;

    // Naturally aligned: halves on even bytes, words on word boundaries
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lane);
        logic ok;
        case (size)
            SZ_H:    ok = ~lane[0];
            SZ_W:    ok = (lane == 2'b00);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: byte enables, store-data replication, load extraction with sign extension.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module mem_lane_align (
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_word,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);
    import mem_pkg::*;

    logic [31:0] byte_shift;
    logic [31:0] half_shift;

    // Bring the addressed byte / half down to bit 0 before extending
    assign byte_shift = rdata_word >> {lane, 3'b000};
    assign half_shift = rdata_word >> {lane[1], 4'b0000};

    // Lane selection per access size, little-endian
    always_comb begin
        be        = 4'b0000;
        wdata_rep = wdata;
        rdata_ext = '0;
        case (size)
            SZ_B: begin
                be        = 4'b0001 << lane;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{byte_shift[7]}}, byte_shift[7:0]};
            end
            SZ_H: begin
                be        = lane[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{half_shift[15]}}, half_shift[15:0]};
            end
            SZ_W: begin
                be        = 4'b1111;
                wdata_rep = wdata;
                rdata_ext = rdata_word;
            end
            default: begin
                be        = 4'b0000;
                wdata_rep = wdata;
                rdata_ext = '0;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences CPU lb/lh/lw/sb/sh/sw onto a word-wide memory with a req/ack handshake.
// Latency: request in cycle 0, m_req from cycle 1, done pulses the cycle after ack (min 2 cycles).
// Backpressure: stall holds the CPU from acceptance until ack or timeout; m_req held until m_ack.
module mem_access_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  mem_read,
    input  logic [1:0]  mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        err_align,
    output logic        err_tmo,
    output logic        m_req,
    output logic        m_we,
    output logic [29:0] m_addr,
    output logic [3:0]  m_be,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack
);
    import mem_pkg::*;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    acc_t               acc, acc_nxt;
    logic               m_req_nxt;
    logic [29:0]        m_addr_nxt;
    logic [3:0]         m_be_nxt;
    logic [31:0]        m_wdata_nxt;
    logic [31:0]        rdata_nxt;
    logic               done_nxt;
    logic               err_align_nxt;
    logic               err_tmo_nxt;

    logic               req_vld;
    logic               req_ok;
    logic [1:0]         req_size;
    logic [1:0]         sel_size;
    logic [1:0]         sel_lane;
    logic [3:0]         lane_be;
    logic [31:0]        lane_wdata;
    logic [31:0]        lane_rdata;

    assign req_vld  = (mem_read != SZ_NONE) || (mem_write != SZ_NONE);
    assign req_size = (mem_read != SZ_NONE) ? mem_read : mem_write;
    assign req_ok   = !((mem_read != SZ_NONE) && (mem_write != SZ_NONE))
                      && is_aligned(req_size, addr[1:0]);

    // One aligner serves both directions: request fields while idle, latched fields afterwards
    assign sel_size = (state == ST_IDLE) ? req_size  : acc.size;
    assign sel_lane = (state == ST_IDLE) ? addr[1:0] : acc.lane;

    mem_lane_align u_align (
        .size       (sel_size),
        .lane       (sel_lane),
        .wdata      (wdata),
        .rdata_word (m_rdata),
        .be         (lane_be),
        .wdata_rep  (lane_wdata),
        .rdata_ext  (lane_rdata)
    );

    assign m_we = acc.we;

    // State and registered outputs; synchronous reset abandons any access in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            acc       <= '0;
            m_req     <= 1'b0;
            m_addr    <= '0;
            m_be      <= '0;
            m_wdata   <= '0;
            rdata     <= '0;
            done      <= 1'b0;
            err_align <= 1'b0;
            err_tmo   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            acc       <= acc_nxt;
            m_req     <= m_req_nxt;
            m_addr    <= m_addr_nxt;
            m_be      <= m_be_nxt;
            m_wdata   <= m_wdata_nxt;
            rdata     <= rdata_nxt;
            done      <= done_nxt;
            err_align <= err_align_nxt;
            err_tmo   <= err_tmo_nxt;
        end
    end

    // Next-state, next register values and the combinational stall
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        acc_nxt       = acc;
        m_req_nxt     = m_req;
        m_addr_nxt    = m_addr;
        m_be_nxt      = m_be;
        m_wdata_nxt   = m_wdata;
        rdata_nxt     = rdata;
        done_nxt      = 1'b0;
        err_align_nxt = 1'b0;
        err_tmo_nxt   = 1'b0;
        stall         = 1'b0;

        case (state)
            ST_IDLE: begin
                if (req_vld) begin
                    if (req_ok) begin
                        stall       = 1'b1;
                        acc_nxt     = '{we: (mem_write != SZ_NONE), size: req_size, lane: addr[1:0]};
                        m_req_nxt   = 1'b1;
                        m_addr_nxt  = addr[31:2];
                        m_be_nxt    = lane_be;
                        m_wdata_nxt = lane_wdata;
                        cnt_nxt     = '0;
                        state_nxt   = ST_WAIT;
                    end else begin
                        err_align_nxt = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                stall = 1'b1;
                if (m_ack) begin
                    // An ack in the final allowed cycle still wins over the timeout
                    m_req_nxt = 1'b0;
                    if (!acc.we) begin
                        rdata_nxt = lane_rdata;
                    end
                    done_nxt  = 1'b1;
                    state_nxt = ST_DONE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    m_req_nxt = 1'b0;
                    if (!acc.we) begin
                        rdata_nxt = '0;
                    end
                    done_nxt    = 1'b1;
                    err_tmo_nxt = 1'b1;
                    state_nxt   = ST_DONE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
